wb_regfile: RTL
===============

# wb_regfile

Architectural state sink for the writeback interface. Consumes the registered writeback bundle: pc, result, writereg, regwrite, hilo_write and hilo. Commits it into a 32x32 general-purpose register file and a 64-bit HI/LO register. Serves two combinational GPR read ports and the HI/LO read port to decode/execute, and drives the NSCSCC debug writeback trace.

## Interface
Parameters:
- RESET_PC, 32'hbfc00000, value of debug_wb_pc while reset is asserted.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- resetn  in  1  reset; asynchronous, active-low.
- wb_pc  in  32  pc of the instruction in writeback.
- wb_result  in  32  GPR write data.
- wb_writereg  in  5  GPR destination index.
- wb_regwrite  in  1  GPR write request.
- wb_hilo_write  in  1  HI/LO write request.
- wb_hilo  in  64  HI/LO write data; HI in [63:32], LO in [31:0].
- raddr1, raddr2  in  5  GPR read indices (rs, rt).
- rdata1, rdata2  out  32  GPR read data.
- hilo_out  out  64  current HI/LO value.
- debug_wb_pc  out  32  trace pc.
- debug_wb_rf_wen  out  4  trace byte write enables.
- debug_wb_rf_wnum  out  5  trace destination index.
- debug_wb_rf_wdata  out  32  trace write data.
- wr_cnt  out  32  count of committed GPR writes.

## Operation
- Effective GPR write: gwe = wb_regwrite && (wb_writereg != 0).
- GPR write:
  - At posedge with gwe=1, gpr[wb_writereg] <= wb_result.
  - r0 is never written and always reads 0.
- HI/LO write: at posedge with wb_hilo_write=1, hilo_reg <= wb_hilo.
- GPR and HI/LO writes are independent; both may occur in the same cycle.
- Read ports:
  - rdata1 and rdata2 are combinational: 0 when the index is 0, else gpr[raddr].
  - Both ports may read the same index.
- hilo_out = hilo_reg (bypass rule below).
- Debug trace, combinational from inputs:
  - debug_wb_pc = wb_pc.
  - debug_wb_rf_wen = {4{gwe}}.
  - debug_wb_rf_wnum = wb_writereg.
  - debug_wb_rf_wdata = wb_result.
- wr_cnt:
  - Increments by 1 at each posedge with gwe=1.
  - 32-bit, wraps from 32'hffffffff to 0.
  - A write with wb_regwrite=1 to r0 does not count.
- Reset (resetn=0), asynchronous:
  - All 31 GPRs, hilo_reg and wr_cnt clear to 0.
  - debug_wb_rf_wen forced to 0.
  - debug_wb_pc forced to RESET_PC.
  - Any write presented while reset is low is discarded.
  - Reset deasserting in the same cycle as a write: the write commits at the first posedge with resetn=1.

## Timing
- Write-to-array latency is 1 cycle: data at posedge N is readable from the array after posedge N.
- Read ports and trace outputs have zero-cycle (combinational) latency.
- No handshake: writes are unconditional when their enable is high. Upstream holds no ready/valid.
- Same-index write and read in one cycle:
  - Governed by the bypass configuration.
  - The array still updates at the edge.

## Configuration
- Macro: WB_REGFILE_BYPASS_EN.
- Defined (write-through bypass):
  - If gwe=1 and raddrN == wb_writereg, rdataN = wb_result in the same cycle.
  - If wb_hilo_write=1, hilo_out = wb_hilo in the same cycle.
  - Removes one hazard cycle from the pipeline.
- Undefined:
  - Reads return the pre-write array value until the edge.
  - The hazard unit must stall one extra cycle on a WB-to-ID dependency.
- The r0 rule holds in both modes: a bypass to index 0 never occurs.

## Test plan
- Reset, then write r5=32'h12345678 (gwe=1), then read raddr1=5 next cycle -> rdata1=32'h12345678; wr_cnt=1; debug_wb_rf_wen=4'hf during the write cycle.
- Write r0=32'hdeadbeef with wb_regwrite=1 -> rdata1(raddr1=0)=0; debug_wb_rf_wen=0; wr_cnt unchanged.
- Same cycle: write r7=32'hcafef00d and read raddr2=7 -> with WB_REGFILE_BYPASS_EN, rdata2=32'hcafef00d that cycle. Without the macro, rdata2 returns the old r7 that cycle and 32'hcafef00d the next cycle.
- wb_hilo_write=1 with wb_hilo=64'h00000001_00000002, plus a concurrent GPR write r3=9 -> next cycle hilo_out=64'h00000001_00000002 and r3=9.
- Fill r1..r31 with distinct values, then assert resetn=0 mid-cycle -> all reads return 0 immediately; hilo_out=0; debug_wb_pc=32'hbfc00000; a write held during reset is not committed.
- Preload wr_cnt to 32'hffffffff via 2^32-1 forced writes (or a force in the bench), then one more gwe cycle -> wr_cnt=0.

Source files
------------

// File: rtl/wb_regfile.sv
// Writeback register file: 32x32 GPRs (r0 hardwired to zero), 64-bit HI/LO, commit counter and debug trace.
// Define WB_REGFILE_BYPASS_EN to forward same-cycle writeback data onto the read ports and hilo_out.
module wb_regfile #(
   parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] wb_pc,
   input  logic [31:0] wb_result,
   input  logic [4:0]  wb_writereg,
   input  logic        wb_regwrite,
   input  logic        wb_hilo_write,
   input  logic [63:0] wb_hilo,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   output logic [63:0] hilo_out,
   output logic [31:0] debug_wb_pc,
   output logic [3:0]  debug_wb_rf_wen,
   output logic [4:0]  debug_wb_rf_wnum,
   output logic [31:0] debug_wb_rf_wdata,
   output logic [31:0] wr_cnt
);

   logic [31:0] gpr_q [1:31];
   logic [63:0] hilo_q;
   logic [31:0] wr_cnt_q;
   logic        gwe;
   logic        hwe;

   // Gating with resetn discards any write (and any bypass) presented while reset is held.
   assign gwe = wb_regwrite && (wb_writereg != 5'd0) && resetn;
   assign hwe = wb_hilo_write && resetn;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 1; i < 32; i++) gpr_q[i] <= '0;
         hilo_q   <= '0;
         wr_cnt_q <= '0;
      end else begin
         if (gwe) begin
            gpr_q[wb_writereg] <= wb_result;
            wr_cnt_q           <= wr_cnt_q + 32'd1;
         end
         if (hwe) hilo_q <= wb_hilo;
      end
   end

   always_comb begin
      rdata1 = '0;
      rdata2 = '0;
      if (raddr1 != 5'd0) begin
         rdata1 = gpr_q[raddr1];
`ifdef WB_REGFILE_BYPASS_EN
         if (gwe && (raddr1 == wb_writereg)) rdata1 = wb_result;
`endif
      end
      if (raddr2 != 5'd0) begin
         rdata2 = gpr_q[raddr2];
`ifdef WB_REGFILE_BYPASS_EN
         if (gwe && (raddr2 == wb_writereg)) rdata2 = wb_result;
`endif
      end
   end

`ifdef WB_REGFILE_BYPASS_EN
   assign hilo_out = hwe ? wb_hilo : hilo_q;
`else
   assign hilo_out = hilo_q;
`endif

   assign wr_cnt            = wr_cnt_q;
   assign debug_wb_pc       = resetn ? wb_pc : RESET_PC;
   assign debug_wb_rf_wen   = {4{gwe}};
   assign debug_wb_rf_wnum  = wb_writereg;
   assign debug_wb_rf_wdata = wb_result;

endmodule
